uart_rx_frame_ctrl: RTL and testbench

//  Sequences the byte stream from uart_byte_rx (rx_data/rx_done) into command frames:

---
 rtl/uart_frame_pkg.sv | 20 ++
 rtl/uart_rx_frame_ctrl_if.sv | 10 +
 rtl/uart_frame_buf.sv | 24 ++
 rtl/uart_rx_frame_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_uart_rx_frame_ctrl.sv | 319 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_frame_pkg.sv
// Shared types and constants for the UART command-frame receiver: FSM states,
// error codes and the default start-of-frame byte.
package uart_frame_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_LEN,
    ST_PAYLOAD,
    ST_CHK,
    ST_OUT
  } state_e;

  localparam logic [1:0] ERR_LEN = 2'd1;
  localparam logic [1:0] ERR_CHK = 2'd2;
  localparam logic [1:0] ERR_TMO = 2'd3;

  localparam logic [7:0] HEADER_DEF = 8'h55;

endpackage

// File: rtl/uart_rx_frame_ctrl_if.sv
// Valid/ready byte stream carrying the replayed payload of an accepted frame.
interface uart_rx_frame_ctrl_if;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;

  modport master (output out_data, output out_valid, output out_last, input out_ready);
  modport slave  (input out_data, input out_valid, input out_last, output out_ready);
endinterface

// File: rtl/uart_frame_buf.sv
// Payload buffer: DEPTH x 8 register file, one synchronous write port and an
// asynchronous read at the same address.
module uart_frame_buf #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [7:0]    wdata_i,
  output logic [7:0]    rdata_o
);

  logic [7:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// Frames the uart_byte_rx byte stream (HEADER CMD LEN payload CHK), validates it and
// replays good payloads on a valid/ready stream. Optional inter-byte timeout: UART_FRAME_TIMEOUT_EN.
module uart_rx_frame_ctrl
  import uart_frame_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 50_000_000,
  parameter int unsigned TIMEOUT_US = 1000,
  parameter int unsigned MAX_LEN    = 16,
  parameter logic [7:0]  HEADER     = HEADER_DEF
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic [7:0] rx_data,
  input  logic       rx_done,
  output logic [7:0] frame_cmd,
  output logic [7:0] frame_len,
  output logic       frame_ok,
  output logic       frame_err,
  output logic [1:0] err_code,
  output logic       rx_drop,
  output logic       busy,
  uart_rx_frame_ctrl_if.master out_if
);

  localparam int unsigned AW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [7:0]  MAX_LEN_B = 8'(MAX_LEN);

  state_e     state_q, state_d;
  logic [7:0] cmd_q, cmd_d;
  logic [7:0] len_q, len_d;
  logic [7:0] sum_q, sum_d;
  logic [7:0] idx_q, idx_d;
  logic [7:0] frame_cmd_q, frame_cmd_d;
  logic [7:0] frame_len_q, frame_len_d;
  logic       ok_q, ok_d;
  logic       err_q, err_d;
  logic [1:0] code_q, code_d;
  logic       drop_q, drop_d;
  logic       buf_we;
  logic [7:0] buf_rdata;
  logic       last_beat;

`ifdef UART_FRAME_TIMEOUT_EN
  localparam logic [31:0] TMO_LIMIT = 32'(CLK_FREQ / 1_000_000 * TIMEOUT_US - 1);
  logic [31:0] tmo_q, tmo_d;
`endif

  // Index doubles as payload write pointer and replay read pointer.
  uart_frame_buf #(
    .DEPTH (MAX_LEN),
    .AW    (AW)
  ) u_buf (
    .clk_i   (sys_clk),
    .we_i    (buf_we),
    .addr_i  (idx_q[AW-1:0]),
    .wdata_i (rx_data),
    .rdata_o (buf_rdata)
  );

  assign last_beat = (state_q == ST_OUT) && (idx_q == len_q - 8'd1);

  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    len_d       = len_q;
    sum_d       = sum_q;
    idx_d       = idx_q;
    frame_cmd_d = frame_cmd_q;
    frame_len_d = frame_len_q;
    ok_d        = 1'b0;
    err_d       = 1'b0;
    code_d      = code_q;
    drop_d      = 1'b0;
    buf_we      = 1'b0;
`ifdef UART_FRAME_TIMEOUT_EN
    tmo_d       = '0;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (rx_done && rx_data == HEADER) state_d = ST_CMD;
      end
      ST_CMD: begin
        if (rx_done) begin
          cmd_d   = rx_data;
          sum_d   = rx_data;
          state_d = ST_LEN;
        end
      end
      ST_LEN: begin
        if (rx_done) begin
          if (rx_data > MAX_LEN_B) begin
            err_d   = 1'b1;
            code_d  = ERR_LEN;
            state_d = ST_IDLE;
          end else begin
            len_d   = rx_data;
            sum_d   = sum_q + rx_data;
            idx_d   = '0;
            state_d = (rx_data == 8'd0) ? ST_CHK : ST_PAYLOAD;
          end
        end
      end
      ST_PAYLOAD: begin
        if (rx_done) begin
          buf_we = 1'b1;
          sum_d  = sum_q + rx_data;
          idx_d  = idx_q + 8'd1;
          if (idx_q + 8'd1 == len_q) state_d = ST_CHK;
        end
      end
      ST_CHK: begin
        if (rx_done) begin
          if (rx_data == sum_q) begin
            frame_cmd_d = cmd_q;
            frame_len_d = len_q;
            ok_d        = 1'b1;
            idx_d       = '0;
            state_d     = (len_q != 8'd0) ? ST_OUT : ST_IDLE;
          end else begin
            err_d   = 1'b1;
            code_d  = ERR_CHK;
            state_d = ST_IDLE;
          end
        end
      end
      ST_OUT: begin
        drop_d = rx_done;
        if (out_if.out_ready) begin
          if (last_beat) state_d = ST_IDLE;
          else           idx_d   = idx_q + 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
`ifdef UART_FRAME_TIMEOUT_EN
    // A byte arriving on the expiry cycle wins: the counter only advances when idle.
    if ((state_q inside {ST_CMD, ST_LEN, ST_PAYLOAD, ST_CHK}) && !rx_done) begin
      if (tmo_q == TMO_LIMIT) begin
        err_d   = 1'b1;
        code_d  = ERR_TMO;
        state_d = ST_IDLE;
      end else begin
        tmo_d = tmo_q + 32'd1;
      end
    end
`endif
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q     <= ST_IDLE;
      cmd_q       <= '0;
      len_q       <= '0;
      sum_q       <= '0;
      idx_q       <= '0;
      frame_cmd_q <= '0;
      frame_len_q <= '0;
      ok_q        <= 1'b0;
      err_q       <= 1'b0;
      code_q      <= '0;
      drop_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      len_q       <= len_d;
      sum_q       <= sum_d;
      idx_q       <= idx_d;
      frame_cmd_q <= frame_cmd_d;
      frame_len_q <= frame_len_d;
      ok_q        <= ok_d;
      err_q       <= err_d;
      code_q      <= code_d;
      drop_q      <= drop_d;
    end
  end

`ifdef UART_FRAME_TIMEOUT_EN
  always_ff @(posedge sys_clk) begin
    if (sys_rst) tmo_q <= '0;
    else         tmo_q <= tmo_d;
  end
`endif

  assign frame_cmd        = frame_cmd_q;
  assign frame_len        = frame_len_q;
  assign frame_ok         = ok_q;
  assign frame_err        = err_q;
  assign err_code         = code_q;
  assign rx_drop          = drop_q;
  assign busy             = (state_q != ST_IDLE);
  assign out_if.out_valid = (state_q == ST_OUT);
  assign out_if.out_data  = (state_q == ST_OUT) ? buf_rdata : 8'h00;
  assign out_if.out_last  = last_beat;

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Bench for uart_rx_frame_ctrl: directed and random frames checked against a
// frame-level model (expected events derived from the framing rules).
module tb_uart_rx_frame_ctrl;
  import uart_frame_pkg::*;

  localparam int MAX_LEN = 16;
  localparam logic [7:0] HDR = 8'h55;
`ifdef UART_FRAME_TIMEOUT_EN
  localparam int CLK_FREQ   = 1_000_000;
  localparam int TIMEOUT_US = 20;
`else
  localparam int CLK_FREQ   = 50_000_000;
  localparam int TIMEOUT_US = 1000;
`endif

  logic       sys_clk = 1'b0;
  logic       sys_rst = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_done = 1'b0;
  logic [7:0] frame_cmd, frame_len;
  logic       frame_ok, frame_err, rx_drop, busy;
  logic [1:0] err_code;

  uart_rx_frame_ctrl_if ifc();

  uart_rx_frame_ctrl #(
    .CLK_FREQ   (CLK_FREQ),
    .TIMEOUT_US (TIMEOUT_US),
    .MAX_LEN    (MAX_LEN),
    .HEADER     (HDR)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .rx_data   (rx_data),
    .rx_done   (rx_done),
    .frame_cmd (frame_cmd),
    .frame_len (frame_len),
    .frame_ok  (frame_ok),
    .frame_err (frame_err),
    .err_code  (err_code),
    .rx_drop   (rx_drop),
    .busy      (busy),
    .out_if    (ifc)
  );

  always #5 sys_clk = ~sys_clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  // Observed events, collected away from the clock edge.
  int  ok_cyc_q[$];
  int  err_cyc_q[$];
  int  err_val_q[$];
  int  beat_q[$];
  int  last_q[$];
  int  drop_cnt = 0;
  int  first_valid_cyc = -1;
  bit  stall_prev = 1'b0;
  logic [7:0] stall_data = 8'h00;

  // Consumer model: 0 always ready, 1 random, 2 held off
  int  ready_mode = 0;
  int  last_rx_cyc = 0;

  // Reference state of the last good frame / last error
  int  good_cmd = 0;
  int  good_len = 0;
  int  last_code = 0;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  always @(negedge sys_clk) begin
    if (sys_rst) begin
      stall_prev = 1'b0;
    end else begin
      if (frame_ok) ok_cyc_q.push_back(cyc);
      if (frame_err) begin
        err_cyc_q.push_back(cyc);
        err_val_q.push_back(int'(err_code));
      end
      if (rx_drop) drop_cnt++;
      if (ifc.out_valid === 1'b1 && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (stall_prev) begin
        checks++;
        assert ((ifc.out_valid === 1'b1) && (ifc.out_data === stall_data)) else begin
          errors++;
          $error("FAIL stall_hold observed valid=%b data=%h expected valid=1 data=%h",
                 ifc.out_valid, ifc.out_data, stall_data);
        end
      end
      if (ifc.out_valid === 1'b1 && ifc.out_ready === 1'b1) begin
        beat_q.push_back(int'(ifc.out_data));
        last_q.push_back(int'(ifc.out_last));
      end
      stall_prev = (ifc.out_valid === 1'b1) && (ifc.out_ready === 1'b0);
      stall_data = ifc.out_data;
    end
  end

  initial begin
    ifc.out_ready = 1'b1;
    forever begin
      @(posedge sys_clk);
      #1;
      case (ready_mode)
        1:       ifc.out_ready = 1'($urandom_range(0, 1));
        2:       ifc.out_ready = 1'b0;
        default: ifc.out_ready = 1'b1;
      endcase
    end
  end

  task automatic clear_mon();
    ok_cyc_q.delete();
    err_cyc_q.delete();
    err_val_q.delete();
    beat_q.delete();
    last_q.delete();
    drop_cnt = 0;
    first_valid_cyc = -1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge sys_clk);
    rx_data = b;
    rx_done = 1'b1;
    last_rx_cyc = cyc;
    @(negedge sys_clk);
    rx_done = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy !== 1'b0 && n < 2000) begin
      @(negedge sys_clk);
      n++;
    end
    chk({tag, ".idle_within_budget"}, int'(n < 2000), 1);
    repeat (2) @(negedge sys_clk);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".frame_ok"},  int'(frame_ok),      0);
    chk({tag, ".frame_err"}, int'(frame_err),     0);
    chk({tag, ".err_code"},  int'(err_code),      0);
    chk({tag, ".frame_cmd"}, int'(frame_cmd),     0);
    chk({tag, ".frame_len"}, int'(frame_len),     0);
    chk({tag, ".out_valid"}, int'(ifc.out_valid), 0);
    chk({tag, ".out_last"},  int'(ifc.out_last),  0);
    chk({tag, ".out_data"},  int'(ifc.out_data),  0);
    chk({tag, ".rx_drop"},   int'(rx_drop),       0);
    chk({tag, ".busy"},      int'(busy),          0);
  endtask

  // Sends one frame and checks every observable effect against the framing rules.
  task automatic run_frame(input string tag, input int cmd, input int len,
                           input int fixed_pl[$], input bit bad_chk, input bit inject);
    int   pl[$];
    int   sum;
    int   dec_cyc;
    bit   exp_ok;
    int   exp_beats;
    clear_mon();
    exp_ok = (len <= MAX_LEN) && !bad_chk;
    sum = (cmd + len) % 256;
    send_byte(HDR);
    send_byte(8'(cmd));
    send_byte(8'(len));
    if (len <= MAX_LEN) begin
      for (int i = 0; i < len; i++) begin
        pl.push_back((i < fixed_pl.size()) ? fixed_pl[i] : int'($urandom_range(0, 255)));
        sum = (sum + pl[i]) % 256;
        send_byte(8'(pl[i]));
      end
      send_byte(bad_chk ? 8'(sum ^ 8'hA5) : 8'(sum));
    end
    dec_cyc = last_rx_cyc;
    if (inject) begin
      ready_mode = 2;
      send_byte(8'h77);
      repeat (3) @(negedge sys_clk);
      ready_mode = 1;
    end
    wait_idle(tag);

    if (exp_ok) begin
      good_cmd = cmd;
      good_len = len;
    end else begin
      last_code = (len > MAX_LEN) ? int'(ERR_LEN) : int'(ERR_CHK);
    end
    exp_beats = exp_ok ? len : 0;

    chk({tag, ".ok_pulses"},  ok_cyc_q.size(),  int'(exp_ok));
    chk({tag, ".err_pulses"}, err_cyc_q.size(), int'(!exp_ok));
    if (ok_cyc_q.size() > 0) begin
      chk({tag, ".ok_latency"}, ok_cyc_q[0] - dec_cyc, 1);
      chk({tag, ".first_valid_cyc"}, first_valid_cyc, (len > 0) ? ok_cyc_q[0] : -1);
    end
    if (err_cyc_q.size() > 0) begin
      chk({tag, ".err_latency"}, err_cyc_q[0] - dec_cyc, 1);
      chk({tag, ".err_code_pulse"}, err_val_q[0], last_code);
    end
    chk({tag, ".err_code_held"}, int'(err_code),  last_code);
    chk({tag, ".frame_cmd"},     int'(frame_cmd), good_cmd);
    chk({tag, ".frame_len"},     int'(frame_len), good_len);
    chk({tag, ".beats"},         beat_q.size(),   exp_beats);
    for (int i = 0; i < exp_beats && i < beat_q.size(); i++) begin
      chk($sformatf("%s.beat%0d_data", tag, i), beat_q[i], pl[i]);
      chk($sformatf("%s.beat%0d_last", tag, i), last_q[i], int'(i == exp_beats - 1));
    end
    chk({tag, ".drops"}, drop_cnt, int'(inject));
  endtask

  initial begin
    int none[$];
    int t1[$];
    int t5[$];
    int kind, rlen;
    t1 = '{8'h10, 8'h20, 8'h30};
    t5 = '{8'h55, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'hFF};

    repeat (3) @(negedge sys_clk);
    check_zero("reset");
    sys_rst = 1'b0;
    @(negedge sys_clk);

    // Non-header byte in IDLE is ignored silently
    clear_mon();
    send_byte(8'h3C);
    repeat (2) @(negedge sys_clk);
    chk("idle_noise.busy", int'(busy), 0);
    chk("idle_noise.err",  err_cyc_q.size(), 0);

    run_frame("t1_good3",   8'hA1, 3,  t1,   1'b0, 1'b0);
    run_frame("t2_len0",    8'h02, 0,  none, 1'b0, 1'b0);
    run_frame("t3_badchk",  8'hA1, 3,  t1,   1'b1, 1'b0);
    run_frame("t4_toolong", 8'h01, 17, none, 1'b0, 1'b0);
    run_frame("max_len",    8'h7E, MAX_LEN, none, 1'b0, 1'b0);

    ready_mode = 1;
    run_frame("t5_stall_drop", 8'hC4, 8, t5, 1'b0, 1'b1);

    for (int f = 0; f < 12; f++) begin
      kind = int'($urandom_range(0, 9));
      ready_mode = int'($urandom_range(0, 1));
      if (kind == 0) begin
        rlen = int'($urandom_range(MAX_LEN + 1, 255));
        run_frame($sformatf("rnd%0d_len", f), int'($urandom_range(0, 255)), rlen, none, 1'b0, 1'b0);
      end else begin
        rlen = int'($urandom_range(0, MAX_LEN));
        run_frame($sformatf("rnd%0d", f), int'($urandom_range(0, 255)), rlen, none,
                  (kind <= 2), 1'b0);
      end
    end
    ready_mode = 0;

`ifdef UART_FRAME_TIMEOUT_EN
    begin
      int n = 0;
      clear_mon();
      send_byte(HDR);
      send_byte(8'hA1);
      while (err_cyc_q.size() == 0 && n < 200) begin
        @(negedge sys_clk);
        n++;
      end
      chk("t6_timeout.err_seen", err_cyc_q.size(), 1);
      if (err_val_q.size() > 0) chk("t6_timeout.code", err_val_q[0], int'(ERR_TMO));
      wait_idle("t6_timeout");
      last_code = int'(ERR_TMO);
    end
`endif

    // Reset in the middle of a payload
    clear_mon();
    send_byte(HDR);
    send_byte(8'hC3);
    send_byte(8'd5);
    send_byte(8'h11);
    send_byte(8'h22);
    chk("rst_mid.busy_before", int'(busy), 1);
    @(negedge sys_clk);
    sys_rst = 1'b1;
    repeat (2) @(negedge sys_clk);
    check_zero("rst_mid");
    sys_rst = 1'b0;
    good_cmd = 0;
    good_len = 0;
    last_code = 0;
    send_byte(8'h33);
    send_byte(8'h44);
    send_byte(8'h66);
    repeat (5) @(negedge sys_clk);
    chk("rst_mid.no_ok",    ok_cyc_q.size(),  0);
    chk("rst_mid.no_err",   err_cyc_q.size(), 0);
    chk("rst_mid.no_beats", beat_q.size(),    0);
    chk("rst_mid.busy_after", int'(busy),     0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench time limit");
  end

endmodule
